// File: rtl/dec2bin_seq_if.sv
// Handshake and data bundle between a decimal-entry front end and the BCD-to-binary converter.
// The master drives the request and operand; the slave returns status and the converted result.
interface dec2bin_seq_if #(
    parameter int NDIGITS = 5,
    parameter int BW      = 16
);
    logic                 start;
    logic [4*NDIGITS-1:0] bcd_in;
    logic                 busy;
    logic                 done;
    logic [BW-1:0]        bin_out;
    logic                 err_digit;
    logic                 err_ovf;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err_digit,
        input  err_ovf
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err_digit,
        output err_ovf
    );
endinterface

// File: rtl/dec2bin_seq.sv
// Multi-cycle BCD-to-binary converter: Horner accumulation acc = acc*10 + digit, MSD first,
// one digit per clock, with sticky invalid-digit and overflow detection.
module dec2bin_seq #(
    parameter int NDIGITS = 5,
    parameter int BW      = 16
) (
    input  logic         clk,
    input  logic         rst,
    dec2bin_seq_if.slave bus
);
    localparam int AW = BW + 4;
    localparam int SW = 4 * NDIGITS;
    localparam int CW = $clog2(NDIGITS + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(NDIGITS - 1);
    localparam logic [AW-1:0] BIN_MAX  = {{4{1'b0}}, {BW{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // acc*10 + d as shifts; acc <= 2^BW-1 on entry, so the sum always fits in AW bits.
    function automatic logic [AW-1:0] mac10(input logic [AW-1:0] a, input logic [3:0] d);
        mac10 = {a[AW-4:0], 3'b000} + {a[AW-2:0], 1'b0} + {{(AW-4){1'b0}}, d};
    endfunction

    function automatic logic digit_bad(input logic [3:0] d);
        digit_bad = (d > 4'd9);
    endfunction

    state_t          state_r, state_nxt_s;
    logic [SW-1:0]   shift_r, shift_nxt_s;
    logic [AW-1:0]   acc_r, acc_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic            dig_bad_r, dig_bad_nxt_s;
    logic            ovf_r, ovf_nxt_s;
    logic [3:0]      digit_s;
    logic [AW-1:0]   sum_s;
    logic            load_out_s;
    logic [BW-1:0]   bin_nxt_s;
    logic            err_digit_nxt_s;
    logic            err_ovf_nxt_s;

    logic            busy_r;
    logic            done_r;
    logic [BW-1:0]   bin_r;
    logic            err_digit_r;
    logic            err_ovf_r;

    assign digit_s = shift_r[SW-1 -: 4];
    assign sum_s   = mac10(acc_r, digit_s);

    // Next-state and datapath update for the IDLE/CONV/DONE sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        acc_nxt_s     = acc_r;
        cnt_nxt_s     = cnt_r;
        dig_bad_nxt_s = dig_bad_r;
        ovf_nxt_s     = ovf_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s   = ST_CONV;
                    shift_nxt_s   = bus.bcd_in;
                    acc_nxt_s     = {AW{1'b0}};
                    cnt_nxt_s     = {CW{1'b0}};
                    dig_bad_nxt_s = 1'b0;
                    ovf_nxt_s     = 1'b0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_CONV: begin
                shift_nxt_s = {shift_r[SW-5:0], 4'h0};
                if (digit_bad(digit_s)) begin
                    dig_bad_nxt_s = 1'b1;
                end else begin
                    dig_bad_nxt_s = dig_bad_r;
                end
                // Once saturated the accumulator freezes so it stays inside the safe width.
                if (!ovf_r) begin
                    acc_nxt_s = sum_s;
                    if (sum_s > BIN_MAX) begin
                        ovf_nxt_s = 1'b1;
                    end else begin
                        ovf_nxt_s = 1'b0;
                    end
                end else begin
                    acc_nxt_s = acc_r;
                    ovf_nxt_s = 1'b1;
                end
                cnt_nxt_s = cnt_r + CW'(1'b1);
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CONV;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Result selection, applied on the edge that enters DONE; invalid digits outrank overflow.
    always_comb begin
        load_out_s      = (state_r == ST_CONV) && (state_nxt_s == ST_DONE);
        bin_nxt_s       = {BW{1'b0}};
        err_digit_nxt_s = 1'b0;
        err_ovf_nxt_s   = 1'b0;
        if (dig_bad_nxt_s) begin
            bin_nxt_s       = {BW{1'b0}};
            err_digit_nxt_s = 1'b1;
        end else if (ovf_nxt_s) begin
            bin_nxt_s       = {BW{1'b1}};
            err_ovf_nxt_s   = 1'b1;
        end else begin
            bin_nxt_s       = acc_nxt_s[BW-1:0];
        end
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= {SW{1'b0}};
            acc_r     <= {AW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            dig_bad_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            shift_r   <= shift_nxt_s;
            acc_r     <= acc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            dig_bad_r <= dig_bad_nxt_s;
            ovf_r     <= ovf_nxt_s;
        end
    end

    // Registered status and held result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            bin_r       <= {BW{1'b0}};
            err_digit_r <= 1'b0;
            err_ovf_r   <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_DONE);
            if (load_out_s) begin
                bin_r       <= bin_nxt_s;
                err_digit_r <= err_digit_nxt_s;
                err_ovf_r   <= err_ovf_nxt_s;
            end else begin
                bin_r       <= bin_r;
                err_digit_r <= err_digit_r;
                err_ovf_r   <= err_ovf_r;
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.bin_out   = bin_r;
    assign bus.err_digit = err_digit_r;
    assign bus.err_ovf   = err_ovf_r;

endmodule

// File: tb/tb_dec2bin_seq.sv
// Directed self-checking bench for dec2bin_seq: latency, results, error flags, reset and
// start-handling boundaries, all against hand-computed values.
module tb_dec2bin_seq;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    dec2bin_seq_if #(.NDIGITS(5), .BW(16)) bus ();

    dec2bin_seq #(.NDIGITS(5), .BW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion: pulse start, wait for done (bounded), check latency and result.
    task automatic convert(input string tag, input logic [19:0] bcd, input logic [15:0] exp_bin,
                           input logic exp_dig, input logic exp_ovf);
        int lat;
        bus.bcd_in = bcd;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'd5);
        check({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
        check({tag, "_edig"}, 32'(bus.err_digit), 32'(exp_dig));
        check({tag, "_eovf"}, 32'(bus.err_ovf), 32'(exp_ovf));
        tick();
        check({tag, "_end"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int first_done;
        int pos[3];

        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.bcd_in = 20'h00000;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bin", 32'(bus.bin_out), 32'd0);
        check("rst_err", {30'd0, bus.err_digit, bus.err_ovf}, 32'd0);

        // T1 and T2
        convert("t1", 20'h09876, 16'h2694, 1'b0, 1'b0);
        convert("t2a", 20'h65535, 16'hFFFF, 1'b0, 1'b0);
        convert("t2b", 20'h65536, 16'hFFFF, 1'b0, 1'b1);
        convert("t2c", 20'h99999, 16'hFFFF, 1'b0, 1'b1);

        // T4: reset mid-conversion clears the held overflow result
        bus.bcd_in = 20'h00042;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_busy", 32'(bus.busy), 32'd0);
        check("t4_done", 32'(bus.done), 32'd0);
        check("t4_bin", 32'(bus.bin_out), 32'd0);
        check("t4_err", {30'd0, bus.err_digit, bus.err_ovf}, 32'd0);
        tick();
        check("t4_idle", 32'(bus.busy), 32'd0);
        convert("t4r", 20'h00042, 16'h002A, 1'b0, 1'b0);

        // T3
        convert("t3a", 20'h1A234, 16'h0000, 1'b1, 1'b0);
        convert("t3b", 20'hF9999, 16'h0000, 1'b1, 1'b0);

        // T5: start while busy is ignored
        bus.bcd_in = 20'h00100;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 14; i++) begin
            if (i >= 2 && i <= 4) begin
                bus.start  = 1'b1;
                bus.bcd_in = 20'h00200;
            end else begin
                bus.start  = 1'b0;
            end
            tick();
            if (bus.done) ndone = ndone + 1;
        end
        check("t5_npulse", 32'(ndone), 32'd1);
        check("t5_bin", 32'(bus.bin_out), 32'd100);

        // T6: start held high gives one conversion every 7 cycles
        bus.bcd_in = 20'h00007;
        bus.start  = 1'b1;
        ndone = 0;
        for (int i = 0; i <= 20; i++) begin
            tick();
            if (bus.done) begin
                if (ndone < 3) pos[ndone] = i;
                ndone = ndone + 1;
                check("t6_bin", 32'(bus.bin_out), 32'd7);
            end
        end
        bus.start = 1'b0;
        check("t6_npulse", 32'(ndone), 32'd3);
        first_done = pos[0];
        check("t6_first", 32'(first_done), 32'd5);
        check("t6_gap1", 32'(pos[1] - pos[0]), 32'd7);
        check("t6_gap2", 32'(pos[2] - pos[1]), 32'd7);
        for (int i = 0; i < 8; i++) tick();
        check("t6_idle", 32'(bus.busy), 32'd0);

        convert("t6z", 20'h00000, 16'h0000, 1'b0, 1'b0);
        convert("lead", 20'h00305, 16'd305, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
